trap_ctrl: RTL and testbench

- Commit-stage trap sequencer.
- Takes the per-instruction exception flag vector plus the pending timer interrupt and selects one trap by fixed priority.
- Sequences pipeline flush, machine CSR update (mepc/mcause/mtval) and PC redirect to mtvec; mret redirects to mepc.
- Sits between commit and the CSR file / IFU redirect port.

---
 rtl/trap_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap sequencer for an M-mode-only core.
//
// Picks one trap from the committing instruction's exception flags plus the
// pending timer interrupt. It then steps through a pipeline flush, a machine
// CSR write (mepc/mcause/mtval) and a PC redirect to mtvec. An mret is
// handled the same way, except that the CSR write is skipped and the
// redirect goes to mepc.
//
// Optional feature (compile-time macro TRAP_VECTORED_EN):
//   When defined, an interrupt taken while mtvec_i[1:0] == 2'b01 is vectored
//   to base + 4*cause. When undefined, mtvec_i[1:0] is ignored and every
//   trap goes direct to base.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   commit_valid_i      commit request, sampled only in IDLE
//   commit_ready_o      high only in IDLE
//   except_i[15:0]      exception flags; see the bit map in the localparams
//   pc_i, tval_i        PC and trap value of the committing instruction
//   mtvec_i, mepc_i     current CSR values
//   mie_global_i        mstatus.MIE
//   mtie_i              mie.MTIE
//   flush_o             one-cycle pipeline flush pulse
//   csr_we_o            one-cycle write strobe for mepc/mcause/mtval
//   csr_mepc_o, csr_mcause_o, csr_mtval_o
//                       CSR write data; valid with csr_we_o, 0 otherwise
//   trap_enter_o        pulses with csr_we_o; the CSR file stacks MIE
//   mret_o              pulses with flush_o for an mret
//   redirect_valid_o    redirect request
//   redirect_ready_i    IFU accepts the redirect
//   redirect_pc_o       target PC; valid with redirect_valid_o, 0 otherwise
//   dbg_state_o         current FSM state (0 IDLE, 1 FLUSH, 2 CSR_WR,
//                       3 REDIRECT)
//
// Redirect handshake:
//   redirect_valid_o stays high, and redirect_pc_o stays stable, until
//   redirect_ready_i is seen high at a clock edge. The transfer completes
//   at that edge.
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int ECALL_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid_i,
  output logic            commit_ready_o,
  input  logic [15:0]     except_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] tval_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            mie_global_i,
  input  logic            mtie_i,
  output logic            flush_o,
  output logic            csr_we_o,
  output logic [XLEN-1:0] csr_mepc_o,
  output logic [XLEN-1:0] csr_mcause_o,
  output logic [XLEN-1:0] csr_mtval_o,
  output logic            trap_enter_o,
  output logic            mret_o,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [1:0]      dbg_state_o
);

  // Bit positions within except_i.
  localparam int B_FETCH_ACC = 15;
  localparam int B_FETCH_PF  = 14;
  localparam int B_LOAD_ACC  = 13;
  localparam int B_LOAD_PF   = 12;
  localparam int B_STORE_ACC = 11;
  localparam int B_STORE_PF  = 10;
  localparam int B_FETCH_MIS = 9;
  localparam int B_LOAD_MIS  = 8;
  localparam int B_STORE_MIS = 7;
  localparam int B_ECALL     = 6;
  localparam int B_MRET      = 5;
  localparam int B_SRET      = 4;
  localparam int B_URET      = 3;
  localparam int B_ILLEGAL   = 2;
  localparam int B_BREAK     = 1;
  localparam int B_TIMER     = 0;

  typedef enum logic [1:0] {IDLE, FLUSH, CSR_WR, REDIRECT} state_t;

  state_t            state_q;
  logic              commit_ready_q, flush_q, mret_q, csr_we_q, trap_enter_q;
  logic              redirect_valid_q, is_mret_q;
  logic [XLEN-1:0]   mepc_q, mcause_q, mtval_q, target_q;

  logic              irq_pend;
  logic              sync_hit;
  logic              tval_used;
  logic [4:0]        sync_cause;
  logic              take_trap, take_mret;
  logic [XLEN-1:0]   mcause_d, mtval_d, target_d, base;

  // Decode of the request presented in IDLE: fixed priority, with the
  // interrupt ahead of every synchronous exception.
  always_comb begin
    irq_pend   = except_i[B_TIMER] & mie_global_i & mtie_i;
    sync_hit   = 1'b1;
    tval_used  = 1'b1;
    sync_cause = 5'd0;
    if (except_i[B_BREAK]) begin
      sync_cause = 5'd3;
      tval_used  = 1'b0;
    end
    else if (except_i[B_FETCH_PF])  sync_cause = 5'd12;
    else if (except_i[B_FETCH_ACC]) sync_cause = 5'd1;
    // sret/uret do not exist on an M-only core, so they report as illegal.
    else if (except_i[B_ILLEGAL] | except_i[B_SRET] | except_i[B_URET])
      sync_cause = 5'd2;
    else if (except_i[B_FETCH_MIS]) sync_cause = 5'd0;
    else if (except_i[B_ECALL]) begin
      sync_cause = 5'(ECALL_CAUSE);
      tval_used  = 1'b0;
    end
    else if (except_i[B_STORE_MIS]) sync_cause = 5'd6;
    else if (except_i[B_LOAD_MIS])  sync_cause = 5'd4;
    else if (except_i[B_STORE_PF])  sync_cause = 5'd15;
    else if (except_i[B_LOAD_PF])   sync_cause = 5'd13;
    else if (except_i[B_STORE_ACC]) sync_cause = 5'd7;
    else if (except_i[B_LOAD_ACC])  sync_cause = 5'd5;
    else sync_hit = 1'b0;

    take_trap = irq_pend | sync_hit;
    // A masked timer bit can be set alongside mret; it does not block it.
    take_mret = ~take_trap & except_i[B_MRET];

    if (irq_pend) mcause_d = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
    else          mcause_d = {{(XLEN-5){1'b0}}, sync_cause};
    mtval_d = (!irq_pend && tval_used) ? tval_i : '0;

    base     = {mtvec_i[XLEN-1:2], 2'b00};
    target_d = take_mret ? mepc_i : base;
`ifdef TRAP_VECTORED_EN
    if (irq_pend && mtvec_i[1:0] == 2'b01)
      target_d = base + {mcause_d[XLEN-3:0], 2'b00};
`endif
  end

`ifndef TRAP_VECTORED_EN
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      commit_ready_q   <= 1'b1;
      flush_q          <= 1'b0;
      mret_q           <= 1'b0;
      csr_we_q         <= 1'b0;
      trap_enter_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      is_mret_q        <= 1'b0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      target_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A request with nothing to take is accepted as a no-op.
          if (commit_valid_i && (take_trap || take_mret)) begin
            state_q        <= FLUSH;
            commit_ready_q <= 1'b0;
            flush_q        <= 1'b1;
            mret_q         <= take_mret;
            is_mret_q      <= take_mret;
            mepc_q         <= pc_i;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            target_q       <= target_d;
          end
        end
        FLUSH: begin
          flush_q <= 1'b0;
          mret_q  <= 1'b0;
          if (is_mret_q) begin
            state_q          <= REDIRECT;
            redirect_valid_q <= 1'b1;
          end else begin
            state_q      <= CSR_WR;
            csr_we_q     <= 1'b1;
            trap_enter_q <= 1'b1;
          end
        end
        CSR_WR: begin
          csr_we_q         <= 1'b0;
          trap_enter_q     <= 1'b0;
          state_q          <= REDIRECT;
          redirect_valid_q <= 1'b1;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            commit_ready_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign commit_ready_o   = commit_ready_q;
  assign flush_o          = flush_q;
  assign mret_o           = mret_q;
  assign csr_we_o         = csr_we_q;
  assign trap_enter_o     = trap_enter_q;
  assign csr_mepc_o       = csr_we_q ? mepc_q   : '0;
  assign csr_mcause_o     = csr_we_q ? mcause_q : '0;
  assign csr_mtval_o      = csr_we_q ? mtval_q  : '0;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_valid_q ? target_q : '0;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  localparam int XLEN = 32;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            commit_valid_i, commit_ready_o;
  logic [15:0]     except_i;
  logic [XLEN-1:0] pc_i, tval_i, mtvec_i, mepc_i;
  logic            mie_global_i, mtie_i;
  logic            flush_o, csr_we_o, trap_enter_o, mret_o;
  logic [XLEN-1:0] csr_mepc_o, csr_mcause_o, csr_mtval_o;
  logic            redirect_valid_o, redirect_ready_i;
  logic [XLEN-1:0] redirect_pc_o;
  logic [1:0]      dbg_state_o;

  trap_ctrl #(.XLEN(XLEN), .ECALL_CAUSE(11)) dut (
    .clk(clk), .rst(rst),
    .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
    .except_i(except_i), .pc_i(pc_i), .tval_i(tval_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .mie_global_i(mie_global_i), .mtie_i(mtie_i),
    .flush_o(flush_o), .csr_we_o(csr_we_o),
    .csr_mepc_o(csr_mepc_o), .csr_mcause_o(csr_mcause_o), .csr_mtval_o(csr_mtval_o),
    .trap_enter_o(trap_enter_o), .mret_o(mret_o),
    .redirect_valid_o(redirect_valid_o), .redirect_ready_i(redirect_ready_i),
    .redirect_pc_o(redirect_pc_o), .dbg_state_o(dbg_state_o)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic flush, csr_we, trap_enter, mret, rv, cr;
    logic [31:0] rpc, mepc, mcause, mtval;
  } obs_t;

  obs_t obs[4];
  obs_t exp_q[$];

  function automatic obs_t sample();
    obs_t o;
    o.flush = flush_o; o.csr_we = csr_we_o; o.trap_enter = trap_enter_o;
    o.mret = mret_o; o.rv = redirect_valid_o; o.cr = commit_ready_o;
    o.rpc = redirect_pc_o; o.mepc = csr_mepc_o;
    o.mcause = csr_mcause_o; o.mtval = csr_mtval_o;
    return o;
  endfunction

  // ---------------- reference model ----------------
  // Synchronous exceptions in priority order: flag bit and mcause code.
  localparam int PRIO_BIT   [14] = '{1, 14, 15, 2, 4, 3, 9, 6, 7, 8, 10, 12, 11, 13};
  localparam int PRIO_CAUSE [14] = '{3, 12, 1, 2, 2, 2, 0, 11, 6, 4, 15, 13, 7, 5};

  // kind: 0 = no-op, 1 = trap, 2 = mret
  function automatic void model(input logic [15:0] e, input logic mie, input logic mtie,
                                input logic [31:0] tval, input logic [31:0] mtvec,
                                input logic [31:0] mepc, output int kind,
                                output logic [31:0] cause, output logic [31:0] mtv,
                                output logic [31:0] tgt);
    kind = 0; cause = 0; mtv = 0;
    tgt  = {mtvec[31:2], 2'b00};
    if (e[0] && mie && mtie) begin
      kind = 1; cause = 32'h8000_0007;
`ifdef TRAP_VECTORED_EN
      if (mtvec[1:0] == 2'b01) tgt = tgt + 32'd4 * 32'd7;
`endif
      return;
    end
    for (int i = 0; i < 14; i++) begin
      if (e[PRIO_BIT[i]]) begin
        kind  = 1;
        cause = PRIO_CAUSE[i];
        mtv   = (PRIO_BIT[i] == 1 || PRIO_BIT[i] == 6) ? 32'd0 : tval;
        return;
      end
    end
    if (e[5]) begin kind = 2; tgt = mepc; end
  endfunction

  // ---------------- driver ----------------
  // Presents one commit at edge N, then records outputs seen at edges N+1..N+4.
  // When busy is set, garbage is driven while the DUT is in FLUSH.
  task automatic run_txn(input logic [15:0] e, input logic mie, input logic mtie,
                         input logic [31:0] pc, input logic [31:0] tval,
                         input logic [31:0] mtvec, input logic [31:0] mepc, input bit busy);
    @(negedge clk);
    commit_valid_i = 1'b1; except_i = e; mie_global_i = mie; mtie_i = mtie;
    pc_i = pc; tval_i = tval; mtvec_i = mtvec; mepc_i = mepc;
    @(posedge clk); #1;
    obs[0] = sample();
    if (busy) begin
      except_i = 16'($urandom); pc_i = $urandom; tval_i = $urandom;
      mtvec_i = $urandom; mepc_i = $urandom; mie_global_i = 1'b1; mtie_i = 1'b1;
    end else begin
      commit_valid_i = 1'b0;
    end
    @(posedge clk); #1;
    obs[1] = sample();
    commit_valid_i = 1'b0;
    for (int k = 2; k < 4; k++) begin
      @(posedge clk); #1;
      obs[k] = sample();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1; commit_valid_i = 1'b1; except_i = 16'h0004; redirect_ready_i = 1'b1;
    pc_i = '0; tval_i = '0; mtvec_i = '0; mepc_i = '0; mie_global_i = 1'b0; mtie_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = sample(); e = '0; e.cr = 1'b1;
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", o, e); end
    checks++;
    if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
    @(negedge clk); rst = 1'b0; commit_valid_i = 1'b0;
  endtask

  task automatic test_illegal();
    run_txn(16'h0004, 1'b0, 1'b0, 32'h8000_0010, 32'h0000_FFFF, 32'h8000_1000, 32'h0, 1'b1);
    checks++;
    if (obs[0].flush !== 1'b1 || obs[0].csr_we !== 1'b0 || obs[0].cr !== 1'b0) begin
      errors++; $display("FAIL illegal_flush got=%h exp=flush only", obs[0]);
    end
    checks++;
    if (obs[1].csr_we !== 1'b1 || obs[1].trap_enter !== 1'b1 || obs[1].mcause !== 32'd2 ||
        obs[1].mepc !== 32'h8000_0010 || obs[1].mtval !== 32'h0000_FFFF) begin
      errors++; $display("FAIL illegal_csr got=%h exp=we mcause=2 mepc=80000010 mtval=ffff", obs[1]);
    end
    checks++;
    if (obs[2].rv !== 1'b1 || obs[2].rpc !== 32'h8000_1000 || obs[2].csr_we !== 1'b0) begin
      errors++; $display("FAIL illegal_redirect got=%h exp=rv rpc=80001000", obs[2]);
    end
    checks++;
    if (obs[3].cr !== 1'b1 || obs[3].rv !== 1'b0) begin
      errors++; $display("FAIL illegal_idle got=%h exp=cr only", obs[3]);
    end
  endtask

  task automatic test_priority();
    run_txn(16'h2042, 1'b1, 1'b1, 32'h100, 32'h1234, 32'h200, 32'h0, 1'b1);
    checks++;
    if (obs[1].mcause !== 32'd3 || obs[1].mtval !== 32'd0) begin
      errors++; $display("FAIL prio_break got mcause=%h mtval=%h exp=3 0", obs[1].mcause, obs[1].mtval);
    end
    run_txn(16'h4004, 1'b1, 1'b1, 32'h104, 32'hABCD, 32'h200, 32'h0, 1'b1);
    checks++;
    if (obs[1].mcause !== 32'd12 || obs[1].mtval !== 32'hABCD) begin
      errors++; $display("FAIL prio_fetch_pf got mcause=%h mtval=%h exp=c abcd", obs[1].mcause, obs[1].mtval);
    end
  endtask

  task automatic test_interrupt();
    run_txn(16'h0041, 1'b1, 1'b1, 32'h300, 32'h55, 32'h400, 32'h0, 1'b1);
    checks++;
    if (obs[1].mcause !== 32'h8000_0007 || obs[1].mtval !== 32'd0 || obs[1].mepc !== 32'h300) begin
      errors++; $display("FAIL irq_win got=%h exp=mcause 80000007 mtval 0 mepc 300", obs[1]);
    end
    run_txn(16'h0041, 1'b0, 1'b1, 32'h300, 32'h55, 32'h400, 32'h0, 1'b1);
    checks++;
    if (obs[1].mcause !== 32'd11 || obs[1].mtval !== 32'd0) begin
      errors++; $display("FAIL irq_masked got mcause=%h exp=b", obs[1].mcause);
    end
  endtask

  task automatic test_mret();
    run_txn(16'h0020, 1'b0, 1'b0, 32'h500, 32'h0, 32'h8000_1000, 32'h8000_0200, 1'b1);
    checks++;
    if (obs[0].flush !== 1'b1 || obs[0].mret !== 1'b1) begin
      errors++; $display("FAIL mret_flush got=%h exp=flush+mret", obs[0]);
    end
    checks++;
    if (obs[1].rv !== 1'b1 || obs[1].rpc !== 32'h8000_0200 || obs[1].csr_we !== 1'b0 || obs[1].mret !== 1'b0) begin
      errors++; $display("FAIL mret_redirect got=%h exp=rv rpc=80000200", obs[1]);
    end
    checks++;
    if (obs[0].csr_we | obs[1].csr_we | obs[2].csr_we | obs[3].csr_we) begin
      errors++; $display("FAIL mret_no_csr got csr_we seen exp=none");
    end
  endtask

  task automatic test_backpressure();
    redirect_ready_i = 1'b0;
    run_txn(16'h0040, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0000_2003, 32'h0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h0000_2000 || commit_ready_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got rv=%b pc=%h cr=%b exp=1 2000 0",
                           c, redirect_valid_o, redirect_pc_o, commit_ready_o);
      end
    end
    @(negedge clk); redirect_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (commit_ready_o !== 1'b1 || redirect_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_release got cr=%b rv=%b exp=1 0", commit_ready_o, redirect_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    redirect_ready_i = 1'b0;
    run_txn(16'h0004, 1'b0, 1'b0, 32'h700, 32'h9, 32'h800, 32'h0, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    o = sample(); e = '0; e.cr = 1'b1;
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_mid got=%h exp=%h", o, e); end
    @(negedge clk); rst = 1'b0; redirect_ready_i = 1'b1;
  endtask

  task automatic test_vectored();
    logic [31:0] exp_pc;
`ifdef TRAP_VECTORED_EN
    exp_pc = 32'h8000_101C;
`else
    exp_pc = 32'h8000_1000;
`endif
    run_txn(16'h0001, 1'b1, 1'b1, 32'h900, 32'h0, 32'h8000_1001, 32'h0, 1'b1);
    checks++;
    if (obs[2].rpc !== exp_pc) begin
      errors++; $display("FAIL vector_timer got=%h exp=%h", obs[2].rpc, exp_pc);
    end
    // Synchronous exceptions always go to base.
    run_txn(16'h0040, 1'b1, 1'b1, 32'h904, 32'h0, 32'h8000_1001, 32'h0, 1'b1);
    checks++;
    if (obs[2].rpc !== 32'h8000_1000) begin
      errors++; $display("FAIL vector_sync got=%h exp=80001000", obs[2].rpc);
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    logic        mie, mtie;
    logic [31:0] pc, tval, mtvec, mepc, cause, mtv, tgt;
    int          kind;
    obs_t        o, x;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: e = 16'(1) << $urandom_range(0, 15);
        1: e = 16'($urandom) & 16'($urandom);
        2: e = 16'($urandom_range(0, 1));
        default: e = 16'h0020 | 16'($urandom_range(0, 1));
      endcase
      mie = 1'($urandom); mtie = 1'($urandom);
      pc = $urandom; tval = $urandom; mtvec = $urandom; mepc = $urandom;
      model(e, mie, mtie, tval, mtvec, mepc, kind, cause, mtv, tgt);
      o = '0;
      case (kind)
        1: begin
          o.flush = 1'b1; exp_q.push_back(o);
          o = '0; o.csr_we = 1'b1; o.trap_enter = 1'b1;
          o.mepc = pc; o.mcause = cause; o.mtval = mtv; exp_q.push_back(o);
          o = '0; o.rv = 1'b1; o.rpc = tgt; exp_q.push_back(o);
          o = '0; o.cr = 1'b1; exp_q.push_back(o);
        end
        2: begin
          o.flush = 1'b1; o.mret = 1'b1; exp_q.push_back(o);
          o = '0; o.rv = 1'b1; o.rpc = tgt; exp_q.push_back(o);
          o = '0; o.cr = 1'b1; exp_q.push_back(o); exp_q.push_back(o);
        end
        default: begin
          o.cr = 1'b1;
          repeat (4) exp_q.push_back(o);
        end
      endcase
      run_txn(e, mie, mtie, pc, tval, mtvec, mepc, kind != 0);
      for (int k = 0; k < 4; k++) begin
        x = exp_q.pop_front();
        checks++;
        if (obs[k] !== x) begin
          errors++;
          $display("FAIL rand t=%0d e=%h cyc=%0d got=%h exp=%h", t, e, k, obs[k], x);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_illegal();
    test_priority();
    test_interrupt();
    test_mret();
    test_backpressure();
    test_reset_mid();
    test_vectored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
